// File: rtl/rhb_pkg.sv
// Shared constants for the result history buffer.
//   RHB_DEPTH        default number of history entries (power of two, >= 2)
//   RHB_PTR_W        pointer / offset width for the default depth
//   DEBOUNCE_CYCLES  default stable-cycle count for button acceptance
//   MODE_LIVE/BROWSE encoding of the live output
package rhb_pkg;

  localparam int   RHB_DEPTH       = 8;
  localparam int   RHB_PTR_W       = $clog2(RHB_DEPTH);
  localparam int   DEBOUNCE_CYCLES = 1_000_000;

  localparam logic MODE_LIVE       = 1'b1;
  localparam logic MODE_BROWSE     = 1'b0;

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-flop synchroniser, debounce counter and
// rising-edge pulse generator.
//   clk_100MHz  system clock
//   reset       synchronous active-high reset
//   btn_raw     raw asynchronous button level
//   btn_pulse   one-cycle pulse on each accepted 0->1 transition
// Raw-to-pulse latency is 2 + DEBOUNCE_CYCLES clock edges.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = rhb_pkg::DEBOUNCE_CYCLES
) (
  input  logic clk_100MHz,
  input  logic reset,
  input  logic btn_raw,
  output logic btn_pulse
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_p0;
  logic             sync_p1;
  logic             level_p2;
  logic [CNT_W-1:0] cnt_p2;

  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      sync_p0   <= 1'b0;
      sync_p1   <= 1'b0;
      level_p2  <= 1'b0;
      cnt_p2    <= '0;
      btn_pulse <= 1'b0;
    end else begin
      // stage p0/p1: metastability synchroniser
      sync_p0   <= btn_raw;
      sync_p1   <= sync_p0;
      // stage p2: accepted level, any agreement restarts the count
      btn_pulse <= 1'b0;
      if (sync_p1 == level_p2) begin
        cnt_p2 <= '0;
      end else if (cnt_p2 == CNT_LAST) begin
        cnt_p2    <= '0;
        level_p2  <= sync_p1;
        btn_pulse <= sync_p1;
      end else begin
        cnt_p2 <= cnt_p2 + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/result_history_buffer.sv
// Circular history of pipeline writeback results feeding the seven-segment
// display, with button-driven browsing of older entries.
//   clk_100MHz   system clock
//   reset        synchronous active-high reset
//   wb_valid     capture wb_data this cycle
//   wb_data      writeback result
//   btn_prev     raw button: step to an older entry
//   btn_next     raw button: step to a newer entry
//   disp_value   registered value for the display (ALU_res)
//   disp_offset  age of the shown entry, 0 = newest
//   live         1 = LIVE (tracks newest), 0 = BROWSE
//   count        number of valid entries, 0..DEPTH
module result_history_buffer #(
  parameter int DEPTH           = rhb_pkg::RHB_DEPTH,
  parameter int DEBOUNCE_CYCLES = rhb_pkg::DEBOUNCE_CYCLES,
  parameter int DATA_W          = 16
) (
  input  logic                     clk_100MHz,
  input  logic                     reset,
  input  logic                     wb_valid,
  input  logic [DATA_W-1:0]        wb_data,
  input  logic                     btn_prev,
  input  logic                     btn_next,
  output logic [DATA_W-1:0]        disp_value,
  output logic [$clog2(DEPTH)-1:0] disp_offset,
  output logic                     live,
  output logic [$clog2(DEPTH):0]   count
);

  import rhb_pkg::MODE_LIVE;
  import rhb_pkg::MODE_BROWSE;

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wptr;
  logic [PTR_W-1:0]  rd_idx;
  logic [CNT_W-1:0]  count_n;
  logic [CNT_W-1:0]  off_n;
  logic [PTR_W-1:0]  off_sat;
  logic              live_n;
  logic              prev_pulse;
  logic              next_pulse;

  // Clamp the offset to the oldest valid entry and to the buffer depth.
  function automatic logic [PTR_W-1:0] sat_offset(input logic [CNT_W-1:0] off,
                                                  input logic [CNT_W-1:0] cnt);
    logic [CNT_W-1:0] lim;
    lim = (cnt == '0) ? '0 : cnt - CNT_W'(1);
    if (lim > CNT_W'(DEPTH - 1)) lim = CNT_W'(DEPTH - 1);
    return PTR_W'((off > lim) ? lim : off);
  endfunction

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dbnc_prev (
    .clk_100MHz (clk_100MHz),
    .reset      (reset),
    .btn_raw    (btn_prev),
    .btn_pulse  (prev_pulse)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dbnc_next (
    .clk_100MHz (clk_100MHz),
    .reset      (reset),
    .btn_raw    (btn_next),
    .btn_pulse  (next_pulse)
  );

  always_comb begin
    count_n = count;
    if (wb_valid && (count != CNT_W'(DEPTH))) count_n = count + CNT_W'(1);

    off_n  = {1'b0, disp_offset};
    live_n = live;
    // Button step first; simultaneous pulses cancel.
    if (prev_pulse && !next_pulse) begin
      if (count > ({1'b0, disp_offset} + CNT_W'(1))) begin
        off_n  = {1'b0, disp_offset} + CNT_W'(1);
        live_n = MODE_BROWSE;
      end
    end else if (next_pulse && !prev_pulse && (live == MODE_BROWSE)) begin
      if (disp_offset > PTR_W'(1)) begin
        off_n = {1'b0, disp_offset} - CNT_W'(1);
      end else begin
        off_n  = '0;
        live_n = MODE_LIVE;
      end
    end
    // A write while browsing ages the shown entry by one.
    if (wb_valid && (live_n == MODE_BROWSE)) off_n = off_n + CNT_W'(1);
    off_sat = sat_offset(off_n, count_n);

    rd_idx = wptr - PTR_W'(1) - disp_offset;
  end

  // History storage: no reset, entries qualified by count.
  always_ff @(posedge clk_100MHz) begin
    if (wb_valid) mem[wptr] <= wb_data;
  end

  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      wptr        <= '0;
      count       <= '0;
      disp_offset <= '0;
      live        <= MODE_LIVE;
      disp_value  <= '0;
    end else begin
      if (wb_valid) wptr <= wptr + PTR_W'(1);
      count       <= count_n;
      disp_offset <= off_sat;
      live        <= live_n;
      disp_value  <= (count == '0) ? '0 : mem[rd_idx];
    end
  end

endmodule

// File: doc/result_history_buffer.md
Name: result_history_buffer

Overview:
- Upstream feeder for the 4-digit seven-segment display. It drives that display's 16-bit ALU_res input.
- Captures every valid writeback result from the pipeline into an 8-entry circular history.
- Normally shows the newest result (LIVE mode).
- Two debounced push-buttons let the user scroll back through older results (BROWSE mode) and return to LIVE.

Parameters:
- DEPTH, 8, number of history entries; power of two, minimum 2.
- DEBOUNCE_CYCLES, 1_000_000, consecutive stable cycles required to accept a button level (10 ms at 100 MHz).

Ports:
- clk_100MHz  input  1  system clock, 100 MHz
- reset  input  1  synchronous reset, active-high
- wb_valid  input  1  writeback strobe; capture wb_data this cycle
- wb_data  input  16  writeback result value
- btn_prev  input  1  raw asynchronous button: step to an older entry
- btn_next  input  1  raw asynchronous button: step to a newer entry
- disp_value  output  16  value for the display (connects to ALU_res)
- disp_offset  output  log2(DEPTH)  age of the shown entry; 0 = newest
- live  output  1  1 = LIVE mode, 0 = BROWSE mode
- count  output  log2(DEPTH)+1  number of valid entries, 0..DEPTH

Behaviour:
- Clock and reset:
  - Single clock domain. Reset is synchronous and active-high on clk_100MHz; it applies at any time, including mid-debounce or mid-browse.
  - Reset values: disp_value=0, disp_offset=0, live=1, count=0, write pointer=0, synchronisers and debounce counters cleared.
  - Memory contents are not reset; entries are qualified by count.
- Capture:
  - On a cycle with wb_valid=1: mem[wptr]<=wb_data, wptr<=wptr+1 (wraps modulo DEPTH), count<=min(count+1, DEPTH).
  - When full, each new write overwrites the oldest entry.
- Display read:
  - disp_value is registered: disp_value <= mem[(wptr-1-disp_offset) mod DEPTH], computed from the pre-update state.
  - In LIVE mode a write shows on disp_value 2 cycles after the wb_valid cycle.
  - count=0 forces disp_value=0.
- Buttons:
  - Each raw button passes through a 2-flop synchroniser, then debounce.
  - Debounce: the accepted level changes only after the synchronised level differs from it for DEBOUNCE_CYCLES consecutive cycles. Any bounce restarts the counter.
  - A one-cycle press pulse is emitted on each 0->1 transition of the accepted level. Raw-to-pulse latency is 2+DEBOUNCE_CYCLES cycles.
- Mode control, evaluated on each cycle. Pulses and wb_valid may coincide.
  - prev pulse only: if count>disp_offset+1, then disp_offset+1 and live<=0. Otherwise no change (saturate at oldest). With count<=1 it stays LIVE.
  - next pulse only: if disp_offset>1, then disp_offset-1. If disp_offset==1, then disp_offset<=0 and live<=1. If already LIVE, no change.
  - prev and next pulses in the same cycle: both ignored.
  - wb_valid in BROWSE: disp_offset+1 so the same entry stays displayed, saturating at DEPTH-1. At saturation the shown entry becomes the new oldest.
  - wb_valid in LIVE: disp_offset stays 0.
  - wb_valid together with a button pulse: apply the button step first, then the write adjustment, then saturate to DEPTH-1 and to count-1 (post-write count).
- Width rules:
  - Pointer arithmetic is modulo DEPTH. No bounds checking beyond the saturation rules above.

Decomposition:
- Package rhb_pkg holds:
  - RHB_DEPTH default
  - RHB_PTR_W = $clog2(RHB_DEPTH)
  - DEBOUNCE_CYCLES default
  - mode encoding localparams MODE_LIVE=1'b1, MODE_BROWSE=1'b0
- One sub-module, btn_debounce: synchroniser, counter and rising-edge pulse. Parameter DEBOUNCE_CYCLES; ports clk_100MHz, reset, btn_raw, btn_pulse. Instantiated twice.
- The history RAM is inferred inline as distributed RAM, not a separate module.

Test Plan:
All tests run with DEBOUNCE_CYCLES=4.
1. Reset, then wb_valid with 16'h1234 -> count=1, live=1, disp_value=16'h1234 two cycles after the strobe; before that, disp_value=0.
2. Write 10 values 16'h0001..16'h000A -> count=8. Then 8 prev presses -> disp_offset reaches 7 showing 16'h0003; the 8th press is ignored.
3. From disp_offset=7, 7 next presses -> disp_offset=0, live=1 after the 7th press, disp_value=16'h000A.
4. In BROWSE with disp_offset=2 showing 16'h0008, write 16'hBEEF -> disp_offset=3, disp_value is still 16'h0008.
5. Raw btn_prev toggling every 2 cycles for 20 cycles, then held high -> exactly one pulse, 6 cycles after the final rise. Simultaneous stable prev and next presses -> no offset change.
6. Assert reset while in BROWSE with a debounce counting -> next cycle: live=1, disp_offset=0, count=0, disp_value=0, and no stray pulse after release.
